// File: rtl/led_effect_driver.sv
// LED effect driver: output stage between the CPU LED data register and the
// board's active-low LED pins. Applies a CPU-selected effect (static, blink,
// PWM dimming, breathing) to the active-high pattern and drives the pins
// through a register.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high
//   led_data_i active-high LED pattern (1 = LED on)
//   ctrl_we_i  control register write enable
//   ctrl_wd_i  control register write data
//   ctrl_rd_o  control register read-back (live level in [19:16] in BREATHE)
//   lights_o   physical LED drive, active-low (0 = lit)
//
// Control fields: [1:0] mode (00 static, 01 blink, 10 pwm, 11 breathe),
// [7:4] duty, [15:8] blink period in ticks (0 behaves as 1).
module led_effect_driver #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned PWM_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] led_data_i,
  input  logic        ctrl_we_i,
  input  logic [31:0] ctrl_wd_i,
  output logic [31:0] ctrl_rd_o,
  output logic [31:0] lights_o
);

  localparam int unsigned TickW = $clog2(TICK_DIV);
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);
  localparam logic [PWM_W-1:0] LevelMax = {PWM_W{1'b1}};
  // Only mode, duty and period are stored; everything else reads back 0.
  localparam logic [31:0] CtrlMask = 32'h0000_FFF3;

  localparam logic [1:0] ModeStatic  = 2'b00;
  localparam logic [1:0] ModeBlink   = 2'b01;
  localparam logic [1:0] ModePwm     = 2'b10;
  localparam logic [1:0] ModeBreathe = 2'b11;

  typedef enum logic {DirUp, DirDown} dir_e;

  logic [31:0]      ctrl_q, ctrl_d;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]       blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;
  logic [PWM_W-1:0] level_q, level_d;
  dir_e             dir_q, dir_d;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [31:0]      lights_q, lights_d;

  logic [1:0] mode;
  logic [3:0] duty;
  logic [7:0] period;
  logic [7:0] period_last;
  logic       tick;
  logic       on;

  always_comb begin
    mode        = ctrl_q[1:0];
    duty        = ctrl_q[7:4];
    period      = ctrl_q[15:8];
    period_last = (period == 8'd0) ? 8'd0 : period - 8'd1;
    tick        = (tick_cnt_q == TickMax);

    ctrl_d      = ctrl_q;
    tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    level_d     = level_q;
    dir_d       = dir_q;
    pwm_cnt_d   = pwm_cnt_q + 1'b1;

    if (tick) begin
      if (blink_cnt_q == period_last) begin
        blink_cnt_d = 8'd0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end

      // Turn around on arrival at an extreme so each extreme lasts one tick.
      if (dir_q == DirUp) begin
        level_d = level_q + 1'b1;
        if (level_q + 1'b1 == LevelMax) dir_d = DirDown;
      end else begin
        level_d = level_q - 1'b1;
        if (level_q == PWM_W'(1)) dir_d = DirUp;
      end
    end

    unique case (mode)
      ModeStatic:  on = 1'b1;
      ModeBlink:   on = phase_q;
      ModePwm:     on = (32'(pwm_cnt_q) < 32'(duty));
      ModeBreathe: on = (pwm_cnt_q < level_q);
      default:     on = 1'b1;
    endcase

    // Uses the pre-write state, so a new mode shows from the following edge.
    lights_d = ~(led_data_i & {32{on}});

    // A write restarts every effect and swallows a coincident tick.
    if (ctrl_we_i) begin
      ctrl_d      = ctrl_wd_i & CtrlMask;
      tick_cnt_d  = '0;
      blink_cnt_d = 8'd0;
      pwm_cnt_d   = '0;
      phase_d     = 1'b1;
      level_d     = '0;
      dir_d       = DirUp;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q      <= 32'd0;
      tick_cnt_q  <= '0;
      blink_cnt_q <= 8'd0;
      phase_q     <= 1'b1;
      level_q     <= '0;
      dir_q       <= DirUp;
      pwm_cnt_q   <= '0;
      lights_q    <= 32'hFFFF_FFFF;
    end else begin
      ctrl_q      <= ctrl_d;
      tick_cnt_q  <= tick_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      level_q     <= level_d;
      dir_q       <= dir_d;
      pwm_cnt_q   <= pwm_cnt_d;
      lights_q    <= lights_d;
    end
  end

  always_comb begin
    ctrl_rd_o = ctrl_q;
    if (mode == ModeBreathe) ctrl_rd_o[19:16] = 4'(level_q);
  end

  assign lights_o = lights_q;

endmodule

// File: tb/tb_led_effect_driver.sv
module tb_led_effect_driver;

  logic        clk;
  logic        reset;
  logic [31:0] led_data;
  logic        ctrl_we;
  logic [31:0] ctrl_wd;
  logic [31:0] ctrl_rd;
  logic [31:0] lights;

  int checks;
  int errors;

  led_effect_driver #(
    .TICK_DIV(4),
    .PWM_W   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .led_data_i(led_data),
    .ctrl_we_i (ctrl_we),
    .ctrl_wd_i (ctrl_wd),
    .ctrl_rd_o (ctrl_rd),
    .lights_o  (lights)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are then read mid-cycle.
  task automatic step();
    @(negedge clk);
  endtask

  // Single-cycle control write; returns at the negedge after the write edge.
  task automatic do_write(input logic [31:0] v);
    ctrl_we = 1'b1;
    ctrl_wd = v;
    step();
    ctrl_we = 1'b0;
  endtask

  // Breathing level after n ticks: 0..15, 14..1, 0, ...
  function automatic int breathe_level(input int n);
    int m;
    m = n % 30;
    return (m <= 15) ? m : 30 - m;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    checks++;
    if (lights !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL reset_lights got %h expected FFFFFFFF", lights);
    end
    checks++;
    if (ctrl_rd !== 32'h0) begin
      errors++;
      $display("FAIL reset_ctrl_rd got %h expected 00000000", ctrl_rd);
    end
    reset    = 1'b0;
    led_data = 32'h0000_00A5;
    step();
    checks++;
    if (lights !== 32'hFFFF_FF5A) begin
      errors++;
      $display("FAIL static_a5 got %h expected FFFFFF5A", lights);
    end
  endtask

  task automatic test_ctrl_mask();
    do_write(32'hFFFF_FFF1);
    checks++;
    if (ctrl_rd !== 32'h0000_FFF1) begin
      errors++;
      $display("FAIL ctrl_mask got %h expected 0000FFF1", ctrl_rd);
    end
  endtask

  task automatic test_blink();
    logic [31:0] exp;
    led_data = 32'h0000_000F;
    do_write(32'h0000_0201);
    checks++;
    if (ctrl_rd !== 32'h0000_0201) begin
      errors++;
      $display("FAIL blink_ctrl_rd got %h expected 00000201", ctrl_rd);
    end
    for (int k = 1; k <= 32; k++) begin
      step();
      exp = ((((k - 1) / 8) % 2) == 0) ? 32'hFFFF_FFF0 : 32'hFFFF_FFFF;
      checks++;
      if (lights !== exp) begin
        errors++;
        $display("FAIL blink k=%0d got %h expected %h", k, lights, exp);
      end
    end
  endtask

  task automatic test_pwm();
    logic [31:0] exp;
    led_data = 32'hFFFF_FFFF;
    do_write(32'h0000_0042);
    for (int k = 1; k <= 32; k++) begin
      step();
      exp = (((k - 1) % 16) < 4) ? 32'h0 : 32'hFFFF_FFFF;
      checks++;
      if (lights !== exp) begin
        errors++;
        $display("FAIL pwm_duty4 k=%0d got %h expected %h", k, lights, exp);
      end
    end
    do_write(32'h0000_0002);
    for (int k = 1; k <= 32; k++) begin
      step();
      checks++;
      if (lights !== 32'hFFFF_FFFF) begin
        errors++;
        $display("FAIL pwm_duty0 k=%0d got %h expected FFFFFFFF", k, lights);
      end
    end
  endtask

  task automatic test_breathe();
    logic [31:0] exp_rd;
    logic [31:0] exp_l;
    int          lvl;
    int          prev_lvl;
    led_data = 32'hFFFF_FFFF;
    do_write(32'h0000_0003);
    for (int k = 0; k <= 128; k++) begin
      if (k > 0) step();
      lvl    = breathe_level(k / 4);
      exp_rd = 32'h0000_0003 | (32'(lvl) << 16);
      checks++;
      if (ctrl_rd !== exp_rd) begin
        errors++;
        $display("FAIL breathe_level k=%0d got %h expected %h", k, ctrl_rd, exp_rd);
      end
      if (k > 0) begin
        prev_lvl = breathe_level((k - 1) / 4);
        exp_l    = (((k - 1) % 16) < prev_lvl) ? 32'h0 : 32'hFFFF_FFFF;
        checks++;
        if (lights !== exp_l) begin
          errors++;
          $display("FAIL breathe_lights k=%0d got %h expected %h", k, lights, exp_l);
        end
      end
    end
  endtask

  task automatic test_write_vs_tick_and_reset();
    logic [31:0] exp;
    led_data = 32'h0000_000F;
    do_write(32'h0000_0101);
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (lights !== 32'hFFFF_FFF0) begin
        errors++;
        $display("FAIL wvt_pre k=%0d got %h expected FFFFFFF0", k, lights);
      end
    end
    // The tick is pending this cycle; the write must discard it.
    do_write(32'h0000_0101);
    for (int k = 1; k <= 9; k++) begin
      step();
      exp = (k <= 4 || k == 9) ? 32'hFFFF_FFF0 : 32'hFFFF_FFFF;
      checks++;
      if (lights !== exp) begin
        errors++;
        $display("FAIL wvt_post k=%0d got %h expected %h", k, lights, exp);
      end
    end
    // Reset mid-blink with LEDs lit, alongside a write that must lose.
    reset   = 1'b1;
    ctrl_we = 1'b1;
    ctrl_wd = 32'h0000_0003;
    step();
    reset   = 1'b0;
    ctrl_we = 1'b0;
    checks++;
    if (lights !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL reset_mid_blink got %h expected FFFFFFFF", lights);
    end
    checks++;
    if (ctrl_rd !== 32'h0) begin
      errors++;
      $display("FAIL reset_beats_write got %h expected 00000000", ctrl_rd);
    end
    step();
    checks++;
    if (lights !== 32'hFFFF_FFF0) begin
      errors++;
      $display("FAIL static_after_reset got %h expected FFFFFFF0", lights);
    end
  endtask

  task automatic test_period0();
    logic [31:0] pat;
    logic [31:0] exp;
    led_data = 32'h0000_000F;
    do_write(32'h0000_0001);
    for (int k = 1; k <= 24; k++) begin
      // Pattern change mid-effect must not disturb the blink timing.
      if (k == 3) led_data = 32'h0000_00F0;
      step();
      pat = (k >= 3) ? 32'h0000_00F0 : 32'h0000_000F;
      exp = ((((k - 1) / 4) % 2) == 0) ? ~pat : 32'hFFFF_FFFF;
      checks++;
      if (lights !== exp) begin
        errors++;
        $display("FAIL period0 k=%0d got %h expected %h", k, lights, exp);
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    ctrl_we  = 1'b0;
    ctrl_wd  = 32'h0;
    led_data = 32'h0;
    step();
    test_reset();
    test_ctrl_mask();
    test_blink();
    test_pwm();
    test_breathe();
    test_write_vs_tick_and_reset();
    test_period0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
